register_status_table: RTL and testbench

REGISTER_STATUS_TABLE -- requirements
Module: register_status_table

---
 rtl/register_status_table.sv | 126 ++++++++++++
 tb/tb_register_status_table.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_status_table.sv
// Register status table: per-register value, busy bit and producer tag.
// Combinational operand lookup with commit bypass; registered busy count.
module register_status_table #(
    parameter int N_REG  = 64,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flash,
    input  logic              dispatch_en,
    input  logic              dispatch_has_dest,
    input  logic [5:0]        dispatch_dest,
    input  logic [TAG_W-1:0]  dispatch_tag,
    input  logic [5:0]        src0_addr,
    input  logic [5:0]        src1_addr,
    output logic              src0_ready,
    output logic              src1_ready,
    output logic [DATA_W-1:0] src0_data,
    output logic [DATA_W-1:0] src1_data,
    output logic [TAG_W-1:0]  src0_tag,
    output logic [TAG_W-1:0]  src1_tag,
    input  logic              commit_en,
    input  logic [5:0]        commit_dest,
    input  logic [DATA_W-1:0] commit_data,
    input  logic [TAG_W-1:0]  commit_tag,
    output logic              commit_reject,
    output logic [6:0]        pending_count
);

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } look_t;

    logic [DATA_W-1:0] r_value [N_REG];
    logic [TAG_W-1:0]  r_tag   [N_REG];
    logic [N_REG-1:0]  r_busy;
    logic [6:0]        r_pending;

    logic              w_commit_wr;
    logic              w_commit_clr;
    logic              w_dispatch_wr;
    logic [N_REG-1:0]  w_busy_next;
    logic [6:0]        w_pending_next;
    look_t             w_src0;
    look_t             w_src1;

    // Register 0 is hardwired: ready, data 0. A busy source whose producer
    // is retiring this cycle takes the value straight off the commit port.
    function automatic look_t f_lookup(input logic [5:0] a);
        look_t l;
        l.ready = 1'b1;
        l.data  = '0;
        l.tag   = r_tag[a];
        if (a != 6'd0) begin
            if (!r_busy[a]) begin
                l.data = r_value[a];
            end else if (commit_en && commit_dest == a &&
                         commit_tag == r_tag[a]) begin
                l.data = commit_data;
            end else begin
                l.ready = 1'b0;
            end
        end
        return l;
    endfunction

    // Operand lookups see only pre-dispatch registered state.
    always_comb begin
        w_src0 = f_lookup(src0_addr);
        w_src1 = f_lookup(src1_addr);
    end

    assign src0_ready    = w_src0.ready;
    assign src0_data     = w_src0.data;
    assign src0_tag      = w_src0.tag;
    assign src1_ready    = w_src1.ready;
    assign src1_data     = w_src1.data;
    assign src1_tag      = w_src1.tag;
    assign commit_reject = 1'b0;
    assign pending_count = r_pending;

    assign w_commit_wr   = commit_en && (commit_dest != 6'd0);
    assign w_commit_clr  = w_commit_wr && (r_tag[commit_dest] == commit_tag);
    assign w_dispatch_wr = dispatch_en && dispatch_has_dest && !flash &&
                           (dispatch_dest != 6'd0);

    // Next busy vector: dispatch overrides a same-register clear, flash wins all.
    always_comb begin
        w_busy_next = r_busy;
        if (w_commit_clr) begin
            w_busy_next[commit_dest] = 1'b0;
        end
        if (w_dispatch_wr) begin
            w_busy_next[dispatch_dest] = 1'b1;
        end
        if (flash) begin
            w_busy_next = '0;
        end
        w_pending_next = 7'($countones(w_busy_next));
    end

    // State update; the pending count is the population of the next busy vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy    <= '0;
            r_pending <= '0;
            for (int i = 0; i < N_REG; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else begin
            r_busy    <= w_busy_next;
            r_pending <= w_pending_next;
            if (w_commit_wr) begin
                r_value[commit_dest] <= commit_data;
            end
            if (w_dispatch_wr) begin
                r_tag[dispatch_dest] <= dispatch_tag;
            end
        end
    end

endmodule

// File: tb/tb_register_status_table.sv
// Directed bench for register_status_table with an expected-value queue.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_register_status_table;

    logic        clock = 1'b0;
    logic        reset;
    logic        flash;
    logic        dispatch_en;
    logic        dispatch_has_dest;
    logic [5:0]  dispatch_dest;
    logic [7:0]  dispatch_tag;
    logic [5:0]  src0_addr;
    logic [5:0]  src1_addr;
    logic        src0_ready;
    logic        src1_ready;
    logic [31:0] src0_data;
    logic [31:0] src1_data;
    logic [7:0]  src0_tag;
    logic [7:0]  src1_tag;
    logic        commit_en;
    logic [5:0]  commit_dest;
    logic [31:0] commit_data;
    logic [7:0]  commit_tag;
    logic        commit_reject;
    logic [6:0]  pending_count;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] exp_q[$];

    register_status_table dut (
        .clock(clock), .reset(reset), .flash(flash),
        .dispatch_en(dispatch_en), .dispatch_has_dest(dispatch_has_dest),
        .dispatch_dest(dispatch_dest), .dispatch_tag(dispatch_tag),
        .src0_addr(src0_addr), .src1_addr(src1_addr),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .src0_data(src0_data), .src1_data(src1_data),
        .src0_tag(src0_tag), .src1_tag(src1_tag),
        .commit_en(commit_en), .commit_dest(commit_dest),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .commit_reject(commit_reject), .pending_count(pending_count)
    );

    always #5 clock = ~clock;

    task automatic push(input logic [63:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] obs);
        logic [63:0] e;
        e = exp_q.pop_front();
        n_total++;
        assert (obs === e) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, e);
    endtask

    task automatic idle();
        flash = 0; dispatch_en = 0; dispatch_has_dest = 0;
        dispatch_dest = 0; dispatch_tag = 0;
        commit_en = 0; commit_dest = 0; commit_data = 0; commit_tag = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic disp(input logic [5:0] d, input logic [7:0] t);
        dispatch_en = 1; dispatch_has_dest = 1;
        dispatch_dest = d; dispatch_tag = t;
    endtask

    task automatic cmt(input logic [5:0] d, input logic [7:0] t,
                       input logic [31:0] v);
        commit_en = 1; commit_dest = d; commit_tag = t; commit_data = v;
    endtask

    initial begin
        idle();
        src0_addr = 0; src1_addr = 0;
        reset = 1;
        tick();
        disp(6'd9, 8'h33);
        cmt(6'd9, 8'h00, 32'h1234);
        tick();
        reset = 0; idle();
        src0_addr = 9; src1_addr = 5;
        @(negedge clock);
        push(1); chk("rst_ready0", 64'(src0_ready));
        push(0); chk("rst_data0", 64'(src0_data));
        push(1); chk("rst_ready1", 64'(src1_ready));
        push(0); chk("rst_reject", 64'(commit_reject));
        push(0); chk("rst_pending", 64'(pending_count));

        tick();
        disp(6'd5, 8'h12);
        tick(); idle();
        src0_addr = 5;
        @(negedge clock);
        push(0); chk("r5_ready", 64'(src0_ready));
        push(64'h12); chk("r5_tag", 64'(src0_tag));
        push(1); chk("r5_pending", 64'(pending_count));

        tick();
        cmt(6'd5, 8'h12, 32'hDEADBEEF);
        @(negedge clock);
        push(1); chk("r5_byp_ready", 64'(src0_ready));
        push(64'hDEADBEEF); chk("r5_byp_data", 64'(src0_data));
        tick(); idle();
        @(negedge clock);
        push(1); chk("r5_ready_after", 64'(src0_ready));
        push(64'hDEADBEEF); chk("r5_data_after", 64'(src0_data));
        push(0); chk("r5_pending_after", 64'(pending_count));

        tick();
        disp(6'd7, 8'h01);
        tick();
        disp(6'd7, 8'h02);
        tick(); idle();
        cmt(6'd7, 8'h01, 32'h55);
        src0_addr = 7;
        @(negedge clock);
        push(0); chk("r7_nobypass", 64'(src0_ready));
        tick(); idle();
        @(negedge clock);
        push(0); chk("r7_busy", 64'(src0_ready));
        push(64'h02); chk("r7_tag", 64'(src0_tag));
        push(1); chk("r7_pending", 64'(pending_count));
        tick();
        flash = 1;
        tick(); idle();
        @(negedge clock);
        push(1); chk("r7_flash_ready", 64'(src0_ready));
        push(64'h55); chk("r7_value", 64'(src0_data));
        push(0); chk("r7_flash_pending", 64'(pending_count));

        tick();
        disp(6'd3, 8'h04);
        tick(); idle();
        cmt(6'd3, 8'h04, 32'hAA);
        disp(6'd3, 8'h09);
        src0_addr = 3;
        tick(); idle();
        @(negedge clock);
        push(0); chk("r3_busy", 64'(src0_ready));
        push(64'h09); chk("r3_tag", 64'(src0_tag));
        push(1); chk("r3_pending", 64'(pending_count));

        tick();
        disp(6'd10, 8'h05);
        tick(); idle();
        cmt(6'd10, 8'h05, 32'h77);
        disp(6'd11, 8'h06);
        tick(); idle();
        src0_addr = 10; src1_addr = 11;
        @(negedge clock);
        push(2); chk("setclr_pending", 64'(pending_count));
        push(1); chk("r10_ready", 64'(src0_ready));
        push(0); chk("r11_busy", 64'(src1_ready));
        tick();
        flash = 1;
        tick(); idle();
        src0_addr = 3;
        @(negedge clock);
        push(64'hAA); chk("r3_value", 64'(src0_data));
        push(0); chk("flash2_pending", 64'(pending_count));

        tick();
        disp(6'd1, 8'h01);
        tick();
        disp(6'd2, 8'h02);
        tick();
        disp(6'd3, 8'h03);
        tick(); idle();
        @(negedge clock);
        push(3); chk("three_pending", 64'(pending_count));
        tick();
        flash = 1;
        cmt(6'd1, 8'h77, 32'h10);
        disp(6'd4, 8'h04);
        tick(); idle();
        src0_addr = 1; src1_addr = 4;
        @(negedge clock);
        push(1); chk("fl_r1_ready", 64'(src0_ready));
        push(64'h10); chk("fl_r1_data", 64'(src0_data));
        push(1); chk("fl_r4_ready", 64'(src1_ready));
        push(0); chk("fl_pending", 64'(pending_count));
        tick();
        src0_addr = 2; src1_addr = 3;
        @(negedge clock);
        push(1); chk("fl_r2_ready", 64'(src0_ready));
        push(1); chk("fl_r3_ready", 64'(src1_ready));

        tick();
        disp(6'd20, 8'h20);
        tick(); idle();
        disp(6'd0, 8'h03);
        cmt(6'd0, 8'h00, 32'hFFFF);
        src0_addr = 0;
        @(negedge clock);
        push(1); chk("r0_ready_same", 64'(src0_ready));
        push(0); chk("r0_data_same", 64'(src0_data));
        tick(); idle();
        @(negedge clock);
        push(1); chk("r0_ready", 64'(src0_ready));
        push(0); chk("r0_data", 64'(src0_data));
        push(1); chk("r0_pending", 64'(pending_count));

        tick();
        disp(6'd8, 8'hFF);
        tick(); idle();
        src0_addr = 8;
        @(negedge clock);
        push(64'hFF); chk("wrap_tag", 64'(src0_tag));
        push(2); chk("wrap_pending", 64'(pending_count));
        tick();
        cmt(6'd8, 8'hFF, 32'hC0DE);
        tick(); idle();
        @(negedge clock);
        push(1); chk("wrap_ready", 64'(src0_ready));
        push(64'hC0DE); chk("wrap_data", 64'(src0_data));
        push(1); chk("wrap_pending2", 64'(pending_count));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
